vga_pixel_fetch: RTL

- Pixel pipeline stage placed directly upstream of the VGA output pins; consumes raster position and sync/blank from the VGA timing generator.
- Fetches framebuffer bytes from on-chip memory (RGB332, 2x pixel-doubled) and expands them to 8-bit R/G/B.
- Overlays a crosshair cursor at CoordX/CoordY.
- Re-aligns Hsync/Vsync/Blank so they match the fetched pixel.

---
 rtl/vga_pixel_fetch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage ahead of the VGA pins: reads RGB332 framebuffer bytes (2x doubled),
// expands them to 8-bit colour, overlays a crosshair cursor and re-aligns sync/blank.
module vga_pixel_fetch #(
  parameter int unsigned FB_W    = 320,
  parameter int unsigned FB_H    = 240,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic              Clock50Mhz,
  input  logic              Reset,
  input  logic [10:0]       HCount,
  input  logic [10:0]       VCount,
  input  logic              HsyncIn,
  input  logic              VsyncIn,
  input  logic              ActiveIn,
  input  logic [10:0]       CoordX,
  input  logic [10:0]       CoordY,
  input  logic              CursorEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [7:0]        MemData,
  output logic              Hsync,
  output logic              Vsync,
  output logic              Blank,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B
);

  localparam int unsigned H_LIM = 2 * FB_W;
  localparam int unsigned V_LIM = 2 * FB_H;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic inr;
    logic hit;
  } flags_t;

  // Idle flags: syncs deasserted, nothing visible.
  localparam flags_t FLAGS_IDLE = flags_t'(5'b11000);

  logic              in_range_c;
  logic              hit_c;
  logic [ADDR_W-1:0] addr_c;
  flags_t            dly [MEM_LAT+1];
  flags_t            aligned_c;
  logic [7:0]        r_c;
  logic [7:0]        g_c;
  logic [7:0]        b_c;
  logic              blank_c;

  // Stage A decode: range test, pixel-doubled address, cursor hit.
  always_comb begin
    in_range_c = ActiveIn && (32'(HCount) < H_LIM) && (32'(VCount) < V_LIM);
    addr_c     = ADDR_W'(32'(VCount >> 1) * FB_W + 32'(HCount >> 1));
    hit_c      = CursorEn && ActiveIn && ((HCount == CoordX) || (VCount == CoordY));
  end

  // Stage A register plus MEM_LAT flag stages, so flags line up with MemData.
  always_ff @(posedge Clock50Mhz) begin
    if (!Reset) begin
      MemRd   <= 1'b0;
      MemAddr <= '0;
      for (int unsigned i = 0; i <= MEM_LAT; i++) begin
        dly[i] <= FLAGS_IDLE;
      end
    end else begin
      MemRd <= in_range_c;
      if (in_range_c) begin
        MemAddr <= addr_c;
      end
      dly[0] <= '{hs: HsyncIn, vs: VsyncIn, act: ActiveIn, inr: in_range_c, hit: hit_c};
      for (int unsigned i = 1; i <= MEM_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign aligned_c = dly[MEM_LAT];

  // Stage B colour select: cursor beats memory and border; MemData used only in range.
  always_comb begin
    r_c     = 8'h00;
    g_c     = 8'h00;
    b_c     = 8'h00;
    blank_c = 1'b0;
    if (aligned_c.act) begin
      blank_c = 1'b1;
      if (aligned_c.hit) begin
        r_c = 8'hFF;
        g_c = 8'hFF;
        b_c = 8'hFF;
      end else if (aligned_c.inr) begin
        r_c = {MemData[7:5], MemData[7:5], MemData[7:6]};
        g_c = {MemData[4:2], MemData[4:2], MemData[4:3]};
        b_c = {MemData[1:0], MemData[1:0], MemData[1:0], MemData[1:0]};
      end
    end
  end

  // Output register.
  always_ff @(posedge Clock50Mhz) begin
    if (!Reset) begin
      R     <= 8'h00;
      G     <= 8'h00;
      B     <= 8'h00;
      Blank <= 1'b0;
      Hsync <= 1'b1;
      Vsync <= 1'b1;
    end else begin
      R     <= r_c;
      G     <= g_c;
      B     <= b_c;
      Blank <= blank_c;
      Hsync <= aligned_c.hs;
      Vsync <= aligned_c.vs;
    end
  end

endmodule
